// File: rtl/multiplier_unit.sv
// Byte-serial operand entry, combinational IEEE-754 single-precision multiply and 7-seg hex display.
// Optional build macro ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module multiplier_unit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic [7:0] inputdata,
    input  logic       loaddata,
    output logic       inputdata_ready,
    output logic [6:0] disp3,
    output logic [6:0] disp2,
    output logic [6:0] disp1,
    output logic [6:0] disp0
);

    localparam int unsigned OP_W   = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PAGE_W = 3;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned EXP_W  = 10;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(8);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(7);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(5);
    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
    localparam logic [OP_W-1:0]   QNAN      = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] enter_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   enter_prev;
    logic                   load_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_sync <= '0;
            load_sync  <= '0;
            enter_prev <= 1'b0;
            load_prev  <= 1'b0;
        end else begin
            enter_sync <= {enter_sync[SYNC_STAGES-2:0], enter};
            load_sync  <= {load_sync[SYNC_STAGES-2:0], loaddata};
            enter_prev <= enter_sync[SYNC_STAGES-1];
            load_prev  <= load_sync[SYNC_STAGES-1];
        end
    end

    logic enter_pulse;
    logic load_mode;
    logic load_edge;
    logic load_rise;

    assign enter_pulse = enter_sync[SYNC_STAGES-1] & ~enter_prev;
    assign load_mode   = load_sync[SYNC_STAGES-1];
    assign load_edge   = load_mode ^ load_prev;
    assign load_rise   = load_mode & ~load_prev;

    // ------------------------------------------------------------------
    // Operand capture, byte counter and display page
    // ------------------------------------------------------------------
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [CNT_W-1:0]  count;
    logic [PAGE_W-1:0] page;
    logic [4:0]        byte_base;

    // Byte 0 lands in the most significant byte of each operand.
    assign byte_base = {~count[1:0], 3'b000};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a            <= '0;
            op_b            <= '0;
            count           <= '0;
            page            <= '0;
            inputdata_ready <= 1'b0;
        end else if (load_edge) begin
            // A mode change swallows any enter pulse in the same cycle.
            if (load_rise) begin
                count           <= '0;
                inputdata_ready <= 1'b0;
            end
        end else if (enter_pulse) begin
            if (load_mode) begin
                if (count < CNT_FULL) begin
                    if (count[2])
                        op_b[byte_base +: BYTE_W] <= inputdata;
                    else
                        op_a[byte_base +: BYTE_W] <= inputdata;
                    count <= count + CNT_W'(1);
                    if (count == CNT_LAST)
                        inputdata_ready <= 1'b1;
                end
            end else begin
                page <= (page == PAGE_LAST) ? '0 : page + PAGE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Single-precision multiplier
    // ------------------------------------------------------------------
    logic                     sign_r;
    logic [7:0]               exp_a;
    logic [7:0]               exp_b;
    logic [FRAC_W-1:0]        frac_a;
    logic [FRAC_W-1:0]        frac_b;
    logic                     a_zero, a_inf, a_nan;
    logic                     b_zero, b_inf, b_nan;
    logic [PROD_W-1:0]        prod;
    logic signed [EXP_W-1:0]  exp_sum;
    logic signed [EXP_W-1:0]  exp_norm;
    logic signed [EXP_W-1:0]  exp_fin;
    logic [FRAC_W-1:0]        mant_norm;
    logic [FRAC_W-1:0]        mant_fin;
    logic [OP_W-1:0]          product;

    assign sign_r = op_a[31] ^ op_b[31];
    assign exp_a  = op_a[30:23];
    assign exp_b  = op_b[30:23];
    assign frac_a = op_a[22:0];
    assign frac_b = op_b[22:0];

    // Denormals count as zero; all-ones exponent splits into inf and NaN.
    assign a_zero = (exp_a == 8'h00);
    assign b_zero = (exp_b == 8'h00);
    assign a_inf  = (exp_a == 8'hFF) && (frac_a == '0);
    assign b_inf  = (exp_b == 8'hFF) && (frac_b == '0);
    assign a_nan  = (exp_a == 8'hFF) && (frac_a != '0);
    assign b_nan  = (exp_b == 8'hFF) && (frac_b != '0);

    assign prod      = PROD_W'({1'b1, frac_a}) * PROD_W'({1'b1, frac_b});
    assign exp_sum   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
    assign exp_norm  = exp_sum + $signed({9'd0, prod[PROD_W-1]});
    assign mant_norm = prod[PROD_W-1] ? prod[46:24] : prod[45:23];

`ifdef ROUND_NEAREST_EN
    logic              guard_bit;
    logic              sticky_bit;
    logic              round_up;
    logic              round_carry;
    logic [FRAC_W-1:0] mant_round;

    assign guard_bit  = prod[PROD_W-1] ? prod[23] : prod[22];
    assign sticky_bit = prod[PROD_W-1] ? (|prod[22:0]) : (|prod[21:0]);
    assign round_up   = guard_bit & (sticky_bit | mant_norm[0]);

    // A carry out of the fraction means 1.11..1 rounded to 10.0: fraction wraps to zero.
    assign {round_carry, mant_round} = {1'b0, mant_norm} + SIG_W'(round_up);
    assign mant_fin = mant_round;
    assign exp_fin  = exp_norm + $signed({9'd0, round_carry});
`else
    logic unused_trunc_bits;

    assign unused_trunc_bits = ^prod[22:0];
    assign mant_fin          = mant_norm;
    assign exp_fin           = exp_norm;
`endif

    always_comb begin
        product = {sign_r, exp_fin[7:0], mant_fin};
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero))
            product = QNAN;
        else if (a_inf || b_inf)
            product = {sign_r, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            product = {sign_r, 31'd0};
        else if (exp_fin >= 10'sd255)
            product = {sign_r, 8'hFF, 23'd0};
        else if (exp_fin <= 10'sd0)
            product = {sign_r, 31'd0};
    end

    // ------------------------------------------------------------------
    // Seven-segment display
    // ------------------------------------------------------------------
    function automatic logic [SEG_W-1:0] hex7(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        seg = 7'b1000000;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1000000;
        endcase
        return seg;
    endfunction

    logic [15:0] halfword;

    always_comb begin
        halfword = op_a[31:16];
        case (page)
            3'd0:    halfword = op_a[31:16];
            3'd1:    halfword = op_a[15:0];
            3'd2:    halfword = op_b[31:16];
            3'd3:    halfword = op_b[15:0];
            3'd4:    halfword = product[31:16];
            3'd5:    halfword = product[15:0];
            default: halfword = op_a[31:16];
        endcase
    end

    always_comb begin
        disp3 = hex7(halfword[15:12]);
        disp2 = hex7(halfword[11:8]);
        disp1 = hex7(halfword[7:4]);
        disp0 = hex7(halfword[3:0]);
        if (load_mode) begin
            disp3 = hex7(count);
            disp2 = SEG_BLANK;
            disp1 = hex7(inputdata[7:4]);
            disp0 = hex7(inputdata[3:0]);
        end
    end

endmodule

// File: tb/tb_multiplier_unit.sv
// Randomized self-checking bench for multiplier_unit against an arithmetic reference model.
module tb_multiplier_unit;

    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enter;
    logic [7:0] inputdata;
    logic       loaddata;
    logic       inputdata_ready;
    logic [6:0] disp3, disp2, disp1, disp0;

    multiplier_unit #(.SYNC_STAGES(S)) dut (
        .clk             (clk),
        .reset           (reset),
        .enter           (enter),
        .inputdata       (inputdata),
        .loaddata        (loaddata),
        .inputdata_ready (inputdata_ready),
        .disp3           (disp3),
        .disp2           (disp2),
        .disp1           (disp1),
        .disp0           (disp0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit settled = 1'b0;

    logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference state: operands as one 64-bit word, byte n at bits [63-8n -: 8].
    logic [63:0] m_ops;
    int          m_cnt;
    int          m_page;
    bit          m_ready;
    bit          m_load;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Exact integer product of the significands, then scale and round by remainder.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e, sh;
        bit              s, za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, p, frac;
`ifdef ROUND_NEAREST_EN
        longint unsigned rem, half;
`endif
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (za && ib) || (ia && zb)) return 32'h7FC00000;
        if (ia || ib) return {s, 8'hFF, 23'd0};
        if (za || zb) return {s, 31'd0};
        ma = 64'h800000 + 64'(a[22:0]);
        mb = 64'h800000 + 64'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end
        frac = (p >> sh) - (64'd1 << 23);
`ifdef ROUND_NEAREST_EN
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && frac % 2 == 1)) frac++;
        if (frac == (64'd1 << 23)) begin
            frac = 0;
            e++;
        end
`endif
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(frac)};
    endfunction

    function automatic logic [31:0] expected_outputs();
        logic [15:0] hw;
        logic [31:0] r;
        r = ref_mul(m_ops[63:32], m_ops[31:0]);
        case (m_page)
            0: hw = m_ops[63:48];
            1: hw = m_ops[47:32];
            2: hw = m_ops[31:16];
            3: hw = m_ops[15:0];
            4: hw = r[31:16];
            default: hw = r[15:0];
        endcase
        if (m_load)
            return {3'b0, m_ready, font[m_cnt], 7'h7F, font[inputdata[7:4]], font[inputdata[3:0]]};
        return {3'b0, m_ready, font[hw[15:12]], font[hw[11:8]], font[hw[7:4]], font[hw[3:0]]};
    endfunction

    always @(negedge clk) begin
        if (settled)
            chk("outputs", {3'b0, inputdata_ready, disp3, disp2, disp1, disp0}, expected_outputs());
    end

    task automatic model_reset();
        m_ops   = '0;
        m_cnt   = 0;
        m_page  = 0;
        m_ready = 1'b0;
        m_load  = 1'b0;
    endtask

    task automatic model_enter(input logic [7:0] d);
        if (m_load) begin
            if (m_cnt < 8) begin
                m_ops[63-8*m_cnt -: 8] = d;
                m_cnt++;
                if (m_cnt == 8) m_ready = 1'b1;
            end
        end else begin
            m_page = (m_page + 1) % 6;
        end
    endtask

    // Enter press: effect lands on the (S+1)th edge after the rise, checked every cycle.
    task automatic press(input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        inputdata = d;
        enter     = 1'b1;
        repeat (S + 1) @(posedge clk);
        model_enter(d);
        #1;
        inputdata = 8'($urandom);
        if (hold > int'(S) + 1) repeat (hold - int'(S) - 1) @(posedge clk);
        #1;
        enter = 1'b0;
        repeat (S + 2) @(posedge clk);
    endtask

    task automatic set_load(input bit v);
        settled = 1'b0;
        @(posedge clk);
        #1;
        loaddata  = v;
        inputdata = 8'($urandom);
        repeat (S + 3) @(posedge clk);
        if (v && !m_load) begin
            m_cnt   = 0;
            m_ready = 1'b0;
        end
        m_load  = v;
        settled = 1'b1;
    endtask

    task automatic release_reset();
        settled = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (S + 3) @(posedge clk);
        m_load  = loaddata;
        settled = 1'b1;
    endtask

    task automatic load_pair(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ops;
        ops = {a, b};
        set_load(1'b1);
        for (int i = 0; i < 8; i++) press(ops[63-8*i -: 8], int'($urandom_range(1, 6)));
    endtask

    task automatic walk_pages();
        for (int i = 0; i < 6; i++) press(8'($urandom), int'($urandom_range(1, 4)));
    endtask

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        s = 1'($urandom);
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0: e = 8'h00;
            1: begin e = 8'hFF; f = '0; end
            2: begin e = 8'hFF; f = f | 23'd1; end
            3: e = 8'($urandom_range(190, 254));
            4: e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, f};
    endfunction

    logic [31:0] dir_a [7] = '{32'h3FC00000, 32'h00000000, 32'h7F000000, 32'h3FC00001,
                               32'h3FFFFFFF, 32'h7F7FFFFF, 32'h00800000};
    logic [31:0] dir_b [7] = '{32'hC0000000, 32'h7F800000, 32'h7F000000, 32'h3FC00001,
                               32'h3FFFFFFF, 32'h3F800001, 32'h3F000000};

    initial begin
        enter     = 1'b0;
        loaddata  = 1'b0;
        inputdata = 8'h00;
        reset     = 1'b0;
        model_reset();

        chk("ref 2x3", ref_mul(32'h40000000, 32'h40400000), 32'h40C00000);
        chk("ref 1.5x-2", ref_mul(32'h3FC00000, 32'hC0000000), 32'hC0400000);
        chk("ref 0xinf", ref_mul(32'h00000000, 32'h7F800000), 32'h7FC00000);
        chk("ref overflow", ref_mul(32'h7F000000, 32'h7F000000), 32'h7F800000);
`ifdef ROUND_NEAREST_EN
        chk("ref rounding", ref_mul(32'h3FC00001, 32'h3FC00001), 32'h40100002);
`else
        chk("ref rounding", ref_mul(32'h3FC00001, 32'h3FC00001), 32'h40100001);
`endif

        settled = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset state", {3'b0, inputdata_ready, disp3, disp2, disp1, disp0},
            {4'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
        release_reset();

        load_pair(32'h40000000, 32'h40400000);
        @(negedge clk);
        chk("ready after 8th", 32'(inputdata_ready), 32'd1);
        press(8'hFF, 2);
        @(negedge clk);
        chk("ninth enter ignored", 32'(disp3), 32'(7'b0000000));

        set_load(1'b0);
        repeat (4) press(8'($urandom), 1);
        @(negedge clk);
        chk("page4 40C0", {4'b0, disp3, disp2, disp1, disp0},
            {4'b0, 7'b0011001, 7'b1000000, 7'b1000110, 7'b1000000});
        press(8'h00, 1);
        @(negedge clk);
        chk("page5 0000", {4'b0, disp3, disp2, disp1, disp0},
            {4'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
        press(8'h00, 1);
        @(negedge clk);
        chk("page wrap 4000", {4'b0, disp3, disp2, disp1, disp0},
            {4'b0, 7'b0011001, 7'b1000000, 7'b1000000, 7'b1000000});

        set_load(1'b1);
        inputdata = 8'hA5;
        @(negedge clk);
        chk("load entry display", {3'b0, inputdata_ready, disp3, disp2, disp1, disp0},
            {4'b0, 7'b1000000, 7'b1111111, 7'b0001000, 7'b0010010});
        press(8'h12, 20);
        @(negedge clk);
        chk("held enter one step", 32'(disp3), 32'(7'b1111001));

        press(8'h34, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset mid-load", {3'b0, inputdata_ready, disp3, disp2, disp1, disp0},
            {4'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
        release_reset();

        for (int i = 0; i < 7; i++) begin
            load_pair(dir_a[i], dir_b[i]);
            set_load(1'b0);
            walk_pages();
        end

        for (int i = 0; i < 25; i++) begin
            load_pair(rand_op(), rand_op());
            set_load(1'b0);
            walk_pages();
            repeat (int'($urandom_range(0, 3))) begin
                @(posedge clk);
                #1;
                inputdata = 8'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
